gray_ptr_ctrl: RTL and testbench
================================

GRAY_PTR_CTRL -- requirements
Module: gray_ptr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3: FIFO depth is 2^ADDR_WIDTH; legal range 2..12.
REQ-002 SHALL have parameter IS_WRITE, default 1: 1 = write side (status means full), 0 = read side (status means empty).
REQ-003 SHALL have parameter SYNC_STAGES, default 2: remote-pointer synchronizer depth; legal range 2..4.
REQ-004 SHALL have parameter ALMOST_THRESH, default 1: almost-flag margin in entries; legal range 1..2^ADDR_WIDTH-1.
REQ-005 SHALL have port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_inc  in  1  request to advance the local pointer.
REQ-008 SHALL have port i_remote_gray  in  ADDR_WIDTH+1  gray pointer from the other clock domain, asynchronous.
REQ-009 SHALL have port o_accept  out  1  combinational i_inc AND NOT o_status.
REQ-010 SHALL have port o_addr  out  ADDR_WIDTH  RAM address: low ADDR_WIDTH bits of the binary count.
REQ-011 SHALL have port o_ptr  out  ADDR_WIDTH+1  registered gray pointer for export to the remote domain.
REQ-012 SHALL have port o_status  out  1  registered full (IS_WRITE=1) or empty (IS_WRITE=0).
REQ-013 SHALL have port o_almost  out  1  registered almost-full / almost-empty.
REQ-014 SHALL have port o_level  out  ADDR_WIDTH+1  registered occupancy; present only under the REQ-030 macro.

Function
REQ-015 SHALL hold an ADDR_WIDTH+1-bit binary count; bin_next = bin + o_accept, modulo 2^(ADDR_WIDTH+1).
REQ-016 SHALL compute gray_next = bin_next XOR (bin_next >> 1) and register it into o_ptr in the same edge as bin, so o_ptr changes by exactly one bit per accept.
REQ-017 SHALL pass i_remote_gray through SYNC_STAGES flops; only the last stage (sync_gray) is used by any logic.
REQ-018 SHALL compute rbin = gray-to-binary of sync_gray (bit i = XOR of sync_gray bits ADDR_WIDTH..i).
REQ-019 SHALL compute used = bin_next - rbin when IS_WRITE=1, rbin - bin_next when IS_WRITE=0, modulo 2^(ADDR_WIDTH+1).
REQ-020 SHALL set full next cycle when gray_next equals sync_gray with its two MSBs inverted (IS_WRITE=1).
REQ-021 SHALL set empty next cycle when gray_next equals sync_gray (IS_WRITE=0).
REQ-022 SHALL set o_almost next cycle when used >= 2^ADDR_WIDTH - ALMOST_THRESH (write) or used <= ALMOST_THRESH (read).
REQ-023 SHALL ignore i_inc while o_status is 1: count, o_ptr, o_addr unchanged.
REQ-024 SHALL treat i_inc on the cycle o_status clears as accepted; wrap from all-ones to zero is not a special case.
REQ-025 SHALL have pointer-to-flag latency of one cycle locally and SYNC_STAGES+1 cycles from a remote pointer change.

Reset
REQ-026 SHALL, while i_rst is 1, asynchronously force binary count, o_ptr and all synchronizer stages to 0.
REQ-027 SHALL reset o_status and o_almost to 0 when IS_WRITE=1 and to 1 when IS_WRITE=0.
REQ-028 SHALL reset o_level to 0 when present.
REQ-029 SHALL resume counting on the first rising edge after i_rst falls, with no pending accept kept from before reset.

Configuration
REQ-030 SHALL, with GRAY_PTR_CTRL_LEVEL_EN defined, provide o_level, registered each cycle from used.
REQ-031 SHALL, without GRAY_PTR_CTRL_LEVEL_EN, omit the o_level port and its register; o_almost keeps identical behaviour.

Verification
REQ-032 SHALL cover reset: i_rst=1 mid-count with bin=5 -> o_ptr=0, o_addr=0 immediately; o_status=0 (write) or 1 (read).
REQ-033 SHALL cover write fill: ADDR_WIDTH=3, remote=0, i_inc held -> o_status=1 after 8th accept, o_ptr=4'b1100, o_accept=0, o_addr stays 0.
REQ-034 SHALL cover gray wrap: 16 accepts -> every o_ptr step has Hamming distance 1; 4'b1000 -> 4'b0000 on bin 15->0.
REQ-035 SHALL cover read side: IS_WRITE=0, i_remote_gray 0 -> 4'b0001 -> o_status falls 3 cycles later (SYNC_STAGES=2); one accept -> o_status=1.
REQ-036 SHALL cover almost: write side, ADDR_WIDTH=3, ALMOST_THRESH=2, remote=0, 6 accepts -> o_almost=1, o_level=6 with macro.

Source files
------------

// File: rtl/gray_ptr_ctrl.sv
// Gray-coded FIFO pointer controller for one side of an async FIFO.
// Optional occupancy output o_level is enabled by defining GRAY_PTR_CTRL_LEVEL_EN.
module gray_ptr_ctrl #(
  parameter int ADDR_WIDTH    = 3,
  parameter int IS_WRITE      = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int ALMOST_THRESH = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_inc,
  input  logic [ADDR_WIDTH:0]   i_remote_gray,
  output logic                  o_accept,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [ADDR_WIDTH:0]   o_ptr,
  output logic                  o_status,
  output logic                  o_almost
`ifdef GRAY_PTR_CTRL_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   o_level
`endif
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH            = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] ALMOST_FULL_LVL  = DEPTH - PW'(ALMOST_THRESH);
  localparam logic [PW-1:0] ALMOST_EMPTY_LVL = PW'(ALMOST_THRESH);
  localparam logic [PW-1:0] FULL_FLIP        = {2'b11, {(ADDR_WIDTH-1){1'b0}}};
  localparam logic          FLAG_RST         = (IS_WRITE == 0);

  logic [PW-1:0] bin_q;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_gray;
  logic [PW-1:0] rbin;
  logic [PW-1:0] used;
  logic          status_next;
  logic          almost_next;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    o_accept  = i_inc & ~o_status;
    bin_next  = bin_q + PW'(o_accept);
    gray_next = bin_next ^ (bin_next >> 1);
    sync_gray = sync_q[SYNC_STAGES-1];
    rbin      = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(sync_gray >> i);
    end
    if (IS_WRITE != 0) begin
      used        = bin_next - rbin;
      status_next = (gray_next == (sync_gray ^ FULL_FLIP));
      almost_next = (used >= ALMOST_FULL_LVL);
    end else begin
      used        = rbin - bin_next;
      status_next = (gray_next == sync_gray);
      almost_next = (used <= ALMOST_EMPTY_LVL);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bin_q    <= '0;
      o_ptr    <= '0;
      o_status <= FLAG_RST;
      o_almost <= FLAG_RST;
    end else begin
      bin_q    <= bin_next;
      o_ptr    <= gray_next;
      o_status <= status_next;
      o_almost <= almost_next;
    end
  end

  // NOTE: synchronizer stages are reset so flags are consistent with a zero remote pointer out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= i_remote_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

`ifdef GRAY_PTR_CTRL_LEVEL_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_level <= '0;
    end else begin
      o_level <= used;
    end
  end
`endif

  assign o_addr = bin_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Scoreboard bench for gray_ptr_ctrl: one write-side and one read-side instance.
// Expected values come from a binary-count model of both pointers.
module tb_gray_ptr_ctrl;

  localparam int W_TH = 2;
  localparam int R_TH = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inc_w = 1'b0, inc_r = 1'b0;
  logic [3:0] rem_w = '0, rem_r = '0;
  logic       accept_w, accept_r, status_w, status_r, almost_w, almost_r;
  logic [2:0] addr_w, addr_r;
  logic [3:0] ptr_w, ptr_r;
`ifdef GRAY_PTR_CTRL_LEVEL_EN
  logic [3:0] level_w, level_r;
`endif

  always #5 clk = ~clk;

  gray_ptr_ctrl #(.ADDR_WIDTH(3), .IS_WRITE(1), .SYNC_STAGES(2), .ALMOST_THRESH(W_TH)) u_wr (
    .i_clk(clk), .i_rst(rst), .i_inc(inc_w), .i_remote_gray(rem_w),
    .o_accept(accept_w), .o_addr(addr_w), .o_ptr(ptr_w), .o_status(status_w), .o_almost(almost_w)
`ifdef GRAY_PTR_CTRL_LEVEL_EN
    , .o_level(level_w)
`endif
  );

  gray_ptr_ctrl #(.ADDR_WIDTH(3), .IS_WRITE(0), .SYNC_STAGES(2), .ALMOST_THRESH(R_TH)) u_rd (
    .i_clk(clk), .i_rst(rst), .i_inc(inc_r), .i_remote_gray(rem_r),
    .o_accept(accept_r), .o_addr(addr_r), .o_ptr(ptr_r), .o_status(status_r), .o_almost(almost_r)
`ifdef GRAY_PTR_CTRL_LEVEL_EN
    , .o_level(level_r)
`endif
  );

  typedef enum int {F_PTR, F_ADDR, F_STATUS, F_ALMOST, F_LEVEL} field_e;
  typedef struct {
    int          side;
    field_e      field;
    int unsigned val;
  } exp_t;

  exp_t sb_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  // Model state, index 0 = write side, 1 = read side.
  logic [3:0] m_bin [2];
  logic [3:0] m_s0  [2];
  logic [3:0] m_s1  [2];
  logic       m_status [2];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks_total++;
    if (obs == exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic int unsigned obs_of(input int side, input field_e f);
    case (f)
      F_PTR:    return side ? ptr_r    : ptr_w;
      F_ADDR:   return side ? addr_r   : addr_w;
      F_STATUS: return side ? status_r : status_w;
      F_ALMOST: return side ? almost_r : almost_w;
`ifdef GRAY_PTR_CTRL_LEVEL_EN
      F_LEVEL:  return side ? level_r  : level_w;
`endif
      default:  return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_bin[s] = '0;
      m_s0[s]  = '0;
      m_s1[s]  = '0;
    end
    m_status[0] = 1'b0;
    m_status[1] = 1'b1;
    sb_q.delete();
  endtask

  // Reset asserted away from any clock edge; outputs must clear without a clock.
  task automatic apply_reset();
    inc_w = 1'b0;
    inc_r = 1'b0;
    rst   = 1'b1;
    #1;
    check("rst_wr_ptr",    ptr_w,    0);
    check("rst_wr_addr",   addr_w,   0);
    check("rst_wr_status", status_w, 0);
    check("rst_wr_almost", almost_w, 0);
    check("rst_rd_ptr",    ptr_r,    0);
    check("rst_rd_status", status_r, 1);
    check("rst_rd_almost", almost_r, 1);
`ifdef GRAY_PTR_CTRL_LEVEL_EN
    check("rst_wr_level",  level_w,  0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, push model expectations, clock, pop and compare.
  task automatic cycle(input logic iw, input logic [3:0] rw, input logic ir, input logic [3:0] rr);
    logic       inc, acc, st, al;
    logic [3:0] bn, rb, used;
    inc_w = iw;
    rem_w = rw;
    inc_r = ir;
    rem_r = rr;
    #1;
    for (int s = 0; s < 2; s++) begin
      inc = s ? ir : iw;
      acc = inc && !m_status[s];
      check(s ? "rd_accept" : "wr_accept", s ? accept_r : accept_w, acc);
      bn = m_bin[s] + {3'b000, acc};
      rb = gray2bin(m_s1[s]);
      if (s == 0) begin
        used = bn - rb;
        st   = (used == 4'd8);
        al   = (used >= 4'(8 - W_TH));
      end else begin
        used = rb - bn;
        st   = (used == 4'd0);
        al   = (used <= 4'(R_TH));
      end
      sb_q.push_back('{s, F_PTR,    bin2gray(bn)});
      sb_q.push_back('{s, F_ADDR,   bn[2:0]});
      sb_q.push_back('{s, F_STATUS, st});
      sb_q.push_back('{s, F_ALMOST, al});
`ifdef GRAY_PTR_CTRL_LEVEL_EN
      sb_q.push_back('{s, F_LEVEL,  used});
`endif
      m_bin[s]    = bn;
      m_s1[s]     = m_s0[s];
      m_s0[s]     = s ? rr : rw;
      m_status[s] = st;
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check($sformatf("%s_%s", e.side ? "rd" : "wr", e.field.name()), obs_of(e.side, e.field), e.val);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [3:0] prev;
    logic [3:0] rd_cnt, wr_cnt;
    int         steps;
    logic       wrap_seen;

    model_reset();
    #2;
    apply_reset();

    // Count to 5 on the write side, then reset mid-cycle.
    repeat (5) cycle(1'b1, 4'd0, 1'b0, 4'd0);
    check("wr_bin5_ptr", ptr_w, 4'b0111);
    #3;
    apply_reset();

    // Write fill against a stalled reader.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 4'd0, 1'b0, 4'd0);
      if (i == 4) check("wr_almost_at5", almost_w, 0);
      if (i == 5) begin
        check("wr_almost_at6", almost_w, 1);
`ifdef GRAY_PTR_CTRL_LEVEL_EN
        check("wr_level_at6", level_w, 6);
`endif
      end
      if (i == 6) check("wr_not_full_at7", status_w, 0);
      if (i == 7) check("wr_full_at8", status_w, 1);
    end
    check("wr_full_ptr",    ptr_w,    4'b1100);
    check("wr_full_status", status_w, 1);
    check("wr_full_accept", accept_w, 0);
    check("wr_full_addr",   addr_w,   0);
    apply_reset();

    // Read side: remote write pointer advances once, empty drops after sync latency.
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 4'd0, 1'b0, 4'b0001);
      check($sformatf("rd_empty_lat%0d", k), status_r, (k < 3) ? 1 : 0);
    end
    cycle(1'b0, 4'd0, 1'b1, 4'b0001);
    check("rd_empty_again", status_r, 1);
    check("rd_ptr_after1",  ptr_r,    4'b0001);
    apply_reset();

    // Gray wrap: remote tracks the write pointer so it never fills.
    prev      = ptr_w;
    steps     = 0;
    wrap_seen = 1'b0;
    wr_cnt    = '0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, bin2gray(m_bin[0]), 1'b1, bin2gray(wr_cnt));
      wr_cnt = wr_cnt + 4'd1;
      if (ptr_w != prev) begin
        steps++;
        check("wr_gray_hamming", $countones(ptr_w ^ prev), 1);
        if (prev == 4'b1000) begin
          check("wr_gray_wrap", ptr_w, 4'b0000);
          wrap_seen = 1'b1;
        end
      end
      prev = ptr_w;
    end
    check("wr_wrap_seen", wrap_seen, 1);
    check("wr_wrap_steps", (steps >= 16) ? 1 : 0, 1);
    apply_reset();

    // Random traffic with legal remote pointers on both sides.
    rd_cnt = '0;
    wr_cnt = '0;
    for (int i = 0; i < 200; i++) begin
      if (rd_cnt != m_bin[0] && $urandom_range(0, 2) != 0) rd_cnt = rd_cnt + 4'd1;
      if ((wr_cnt - m_bin[1]) != 4'd8 && $urandom_range(0, 2) != 0) wr_cnt = wr_cnt + 4'd1;
      cycle(1'($urandom_range(0, 1)), bin2gray(rd_cnt), 1'($urandom_range(0, 1)), bin2gray(wr_cnt));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
